// File: rtl/tmr_scrub_pkg.sv
// Shared types and helpers for the TMR scrub scheduler.
// Holds the controller state encoding and the width helper used for its counters.
package tmr_scrub_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      SCRUB = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } scrubState_t;

   // Never returns less than 1, so single-group or tiny-period builds still get a legal vector.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/tmr_scrub_ctrl_if.sv
// Control/status bundle between the scrub scheduler and its slow-control / voter neighbours.
// The controller sits on the slave side; whoever drives enables and mismatch flags is the master.
interface tmr_scrub_ctrl_if #(
   parameter int N_GROUPS = 4,
   parameter int CNT_W    = 16
);

   logic                enable_i;
   logic                force_i;
   logic                clear_i;
   logic [N_GROUPS-1:0] mismatch_i;
   logic [N_GROUPS-1:0] scrub_o;
   logic                busy_o;
   logic                done_o;
   logic [CNT_W-1:0]    err_count_o;
   logic [N_GROUPS-1:0] persist_o;

   modport master (
      output enable_i, force_i, clear_i, mismatch_i,
      input  scrub_o, busy_o, done_o, err_count_o, persist_o
   );

   modport slave (
      input  enable_i, force_i, clear_i, mismatch_i,
      output scrub_o, busy_o, done_o, err_count_o, persist_o
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over an increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Holds at all-ones instead of wrapping, so a flood of upsets never reads as a small count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Periodic scrub scheduler for triplicated register groups: pulses one refresh per group,
// counts mismatches seen before the refresh and latches those still present after it.
module tmr_scrub_ctrl
   import tmr_scrub_pkg::*;
#(
   parameter int N_GROUPS = 4,
   parameter int PERIOD   = 1024,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             rst,
   tmr_scrub_ctrl_if.slave bus
);

   localparam int                GRP_W       = clog2(N_GROUPS);
   localparam int                PCNT_W      = clog2(PERIOD);
   localparam logic [GRP_W-1:0]  LAST_GRP    = GRP_W'(N_GROUPS - 1);
   localparam logic [PCNT_W-1:0] PERIOD_LOAD = PCNT_W'(PERIOD - 1);

   scrubState_t         state;
   scrubState_t         nextState;
   logic [GRP_W-1:0]    grp;
   logic [GRP_W-1:0]    nextGrp;
   logic [PCNT_W-1:0]   periodCnt;
   logic [PCNT_W-1:0]   nextPeriodCnt;
   logic [N_GROUPS-1:0] scrubReg;
   logic [N_GROUPS-1:0] nextScrub;
   logic [N_GROUPS-1:0] persistReg;
   logic                grpMismatch;
   logic                errInc;

   // Only the flag of the group currently being refreshed matters.
   assign grpMismatch = bus.mismatch_i[grp];
   assign errInc      = (state == SCRUB) && grpMismatch;

   // NOTE: reset is synchronous and clears every register, including any half-finished sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grp       <= '0;
         periodCnt <= '0;
         scrubReg  <= '0;
      end else begin
         // NOTE: non-blocking assignments so each register samples the pre-edge values of the others.
         state     <= nextState;
         grp       <= nextGrp;
         periodCnt <= nextPeriodCnt;
         scrubReg  <= nextScrub;
      end
   end

   // NOTE: every variable of this block gets a default first, so no path can infer a latch.
   always_comb begin
      nextState     = state;
      nextGrp       = grp;
      nextPeriodCnt = periodCnt;
      case (state)
         IDLE: begin
            if (bus.force_i) begin
               nextState = SCRUB;
               nextGrp   = '0;
            end else if (bus.enable_i) begin
               nextState     = WAIT;
               nextPeriodCnt = PERIOD_LOAD;
            end
         end
         WAIT: begin
            // Loaded with PERIOD-1 and leaving on zero gives exactly PERIOD idle cycles.
            if ((periodCnt == '0) || bus.force_i) begin
               nextState = SCRUB;
               nextGrp   = '0;
            end else if (!bus.enable_i) begin
               nextState = IDLE;
            end else begin
               nextPeriodCnt = periodCnt - PCNT_W'(1);
            end
         end
         SCRUB: begin
            nextState = CHECK;
         end
         CHECK: begin
            if (grp == LAST_GRP) begin
               nextState = DONE;
            end else begin
               nextState = SCRUB;
               nextGrp   = grp + GRP_W'(1);
            end
         end
         DONE: begin
            if (bus.enable_i) begin
               nextState     = WAIT;
               nextPeriodCnt = PERIOD_LOAD;
            end else begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // The refresh strobe is computed from the next state so the registered copy lines up with SCRUB.
   always_comb begin
      nextScrub  = '0;
      if (nextState == SCRUB) begin
         nextScrub = N_GROUPS'(1) << nextGrp;
      end
      bus.busy_o = (state == SCRUB) || (state == CHECK);
      bus.done_o = (state == DONE);
   end

   sat_counter #(
      .W (CNT_W)
   ) errCounter (
      .clk   (clk),
      .rst   (rst),
      .inc   (errInc),
      .clr   (bus.clear_i),
      .count (bus.err_count_o)
   );

   // A mismatch that outlives the refresh is a persistent fault; clear wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst) begin
         persistReg <= '0;
      end else if (bus.clear_i) begin
         persistReg <= '0;
      end else if ((state == CHECK) && grpMismatch) begin
         persistReg[grp] <= 1'b1;
      end
   end

   assign bus.scrub_o   = scrubReg;
   assign bus.persist_o = persistReg;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl with N_GROUPS=4, PERIOD=8, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point.
module tb_tmr_scrub_ctrl;

   localparam int N_GROUPS = 4;
   localparam int PERIOD   = 8;
   localparam int CNT_W    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nCompared = 0;
   int   nMismatch = 0;

   tmr_scrub_ctrl_if #(.N_GROUPS(N_GROUPS), .CNT_W(CNT_W)) bus ();

   tmr_scrub_ctrl #(
      .N_GROUPS (N_GROUPS),
      .PERIOD   (PERIOD),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance to the SCRUB cycle of group 0 (sweep offset 0), bounded so a dead FSM cannot hang the run.
   task automatic waitScrubStart(input string tag);
      int budget;
      budget = 0;
      while ((bus.scrub_o !== 4'b0001) && (budget < 40)) begin
         tick();
         budget++;
      end
      check({tag, " start"}, 32'(bus.scrub_o), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  anyActivity;
      bus.enable_i   = 1'b0;
      bus.force_i    = 1'b0;
      bus.clear_i    = 1'b0;
      bus.mismatch_i = '0;
      rst            = 1'b1;
      tick(2);
      check("rst scrub",   32'(bus.scrub_o),     32'h0);
      check("rst busy",    32'(bus.busy_o),      32'h0);
      check("rst done",    32'(bus.done_o),      32'h0);
      check("rst err",     32'(bus.err_count_o), 32'h0);
      check("rst persist", 32'(bus.persist_o),   32'h0);

      // 1: enable at cycle 0; WAIT spans cycles 1..8, sweep 9..16, DONE at 17.
      rst          = 1'b0;
      bus.enable_i = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         int expScrub;
         int expBusy;
         int expDone;
         tick();
         expScrub = (c >= 9 && c <= 15 && (c % 2) == 1) ? (1 << ((c - 9) / 2)) : 0;
         expBusy  = (c >= 9 && c <= 16) ? 1 : 0;
         expDone  = (c == 17) ? 1 : 0;
         check($sformatf("t1 scrub c%0d", c), 32'(bus.scrub_o), 32'(expScrub));
         check($sformatf("t1 busy c%0d", c),  32'(bus.busy_o),  32'(expBusy));
         check($sformatf("t1 done c%0d", c),  32'(bus.done_o),  32'(expDone));
      end
      check("t1 err",     32'(bus.err_count_o), 32'h0);
      check("t1 persist", 32'(bus.persist_o),   32'h0);

      // 2: flag on grp2 only during its SCRUB -> counted, not persistent.
      waitScrubStart("t2");
      tick(4);
      check("t2 scrub grp2", 32'(bus.scrub_o), 32'h4);
      bus.mismatch_i = 4'b0100;
      tick();
      bus.mismatch_i = 4'b0000;
      check("t2 err after scrub", 32'(bus.err_count_o), 32'h1);
      tick(3);
      check("t2 done",    32'(bus.done_o),      32'h1);
      check("t2 err",     32'(bus.err_count_o), 32'h1);
      check("t2 persist", 32'(bus.persist_o),   32'h0);

      // 3: clear in WAIT, then grp1 flag held for two sweeps.
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      check("t3 clear err", 32'(bus.err_count_o), 32'h0);
      bus.mismatch_i = 4'b0010;
      waitScrubStart("t3a");
      tick(8);
      check("t3a done",    32'(bus.done_o),      32'h1);
      check("t3a err",     32'(bus.err_count_o), 32'h1);
      check("t3a persist", 32'(bus.persist_o),   32'h2);
      waitScrubStart("t3b");
      tick(8);
      check("t3b err",     32'(bus.err_count_o), 32'h2);
      check("t3b persist", 32'(bus.persist_o),   32'h2);

      // 4: all groups flagged for 5 sweeps -> 4 per sweep, saturating at 15.
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i    = 1'b0;
      bus.mismatch_i = 4'b1111;
      check("t4 clear err",     32'(bus.err_count_o), 32'h0);
      check("t4 clear persist", 32'(bus.persist_o),   32'h0);
      for (int s = 1; s <= 5; s++) begin
         waitScrubStart($sformatf("t4 sweep%0d", s));
         tick(8);
         if (s == 3) check("t4 err after 3", 32'(bus.err_count_o), 32'd12);
      end
      check("t4 err sat",  32'(bus.err_count_o), 32'd15);
      check("t4 persist",  32'(bus.persist_o),   32'hf);
      waitScrubStart("t4 clr");
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i    = 1'b0;
      bus.mismatch_i = 4'b0000;
      check("t4 clr err",     32'(bus.err_count_o), 32'h0);
      check("t4 clr persist", 32'(bus.persist_o),   32'h0);
      tick(7);
      check("t4 clr done", 32'(bus.done_o),      32'h1);
      check("t4 clr err2", 32'(bus.err_count_o), 32'h0);

      // 5: force with cnt=5 (third WAIT cycle), then force mid-sweep is ignored.
      tick(3);
      check("t5 waiting", 32'(bus.scrub_o), 32'h0);
      bus.force_i = 1'b1;
      tick();
      bus.force_i = 1'b0;
      check("t5 forced scrub", 32'(bus.scrub_o), 32'h1);
      tick();
      bus.force_i = 1'b1;
      tick();
      bus.force_i = 1'b0;
      check("t5 scrub grp1", 32'(bus.scrub_o), 32'h2);
      tick(5);
      check("t5 done early", 32'(bus.done_o), 32'h0);
      check("t5 busy late",  32'(bus.busy_o), 32'h1);
      tick();
      check("t5 done",      32'(bus.done_o), 32'h1);
      check("t5 busy done", 32'(bus.busy_o), 32'h0);

      // 6: enable dropped at grp1 CHECK -> sweep completes, then IDLE.
      waitScrubStart("t6");
      tick(3);
      bus.enable_i = 1'b0;
      tick(5);
      check("t6 done", 32'(bus.done_o), 32'h1);
      tick();
      check("t6 idle busy",  32'(bus.busy_o),  32'h0);
      check("t6 idle scrub", 32'(bus.scrub_o), 32'h0);
      anyActivity = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if ((bus.scrub_o != '0) || bus.busy_o) anyActivity = 1;
      end
      check("t6 stays idle", 32'(anyActivity), 32'h0);

      // Force from IDLE, then reset in the middle of the sweep.
      bus.mismatch_i = 4'b0001;
      bus.force_i    = 1'b1;
      tick();
      bus.force_i = 1'b0;
      check("t6 force idle", 32'(bus.scrub_o), 32'h1);
      tick(4);
      check("t6 scrub grp2",  32'(bus.scrub_o),     32'h4);
      check("t6 err pre",     32'(bus.err_count_o), 32'h1);
      check("t6 persist pre", 32'(bus.persist_o),   32'h1);
      rst = 1'b1;
      tick();
      check("t6 rst scrub",   32'(bus.scrub_o),     32'h0);
      check("t6 rst busy",    32'(bus.busy_o),      32'h0);
      check("t6 rst done",    32'(bus.done_o),      32'h0);
      check("t6 rst err",     32'(bus.err_count_o), 32'h0);
      check("t6 rst persist", 32'(bus.persist_o),   32'h0);

      // Restart timing from IDLE must match the very first sweep.
      rst            = 1'b0;
      bus.mismatch_i = 4'b0000;
      bus.enable_i   = 1'b1;
      tick(8);
      check("t6 restart c8", 32'(bus.scrub_o), 32'h0);
      tick();
      check("t6 restart c9", 32'(bus.scrub_o), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
